// File: rtl/alu_pkg.sv
// Shared ALU definitions: default operand geometry (also used by the adder) and sequencer FSM encodings.
package alu_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CHUNK_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub_slice.sv
// Combinational CHUNK-bit subtract with borrow: {bout, d} = a - b - bin.
// Zero latency, no flow control.
module sub_slice
    import alu_pkg::*;
#(
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);

    logic [CHUNK:0] res;

    // A negative result sets the extra top bit, which is exactly the borrow out.
    always_comb begin
        res  = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};
        d    = res[CHUNK-1:0];
        bout = res[CHUNK];
    end

endmodule

// File: rtl/subtractor_seq.sv
// Multi-cycle A - B - bin, CHUNK bits/cycle LSB first; SUB_OVERFLOW_FLAG_EN adds the signed overflow output ovf.
// Latency WIDTH/CHUNK cycles after accept, done pulses for one cycle; start is ignored while busy.
module subtractor_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH % CHUNK != 0) begin : g_chunk_chk
        $error("subtractor_seq: WIDTH must be a multiple of CHUNK");
    end

    state_t           state, state_nxt;
    logic             accept;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nxt, d_ext;
    logic             brw;
    logic [CHUNK-1:0] sl_d;
    logic             sl_bout;
`ifdef SUB_OVERFLOW_FLAG_EN
    logic             a_msb, b_msb;
`endif

    sub_slice #(.CHUNK(CHUNK)) u_slice (
        .a    (a_sh[CHUNK-1:0]),
        .b    (b_sh[CHUNK-1:0]),
        .bin  (brw),
        .d    (sl_d),
        .bout (sl_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // DONE doubles as an accept slot so back-to-back ops need no idle cycle.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                busy = 1'b1;
                if (cnt == LAST) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_CALC;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // New chunk enters at the top; after N shifts chunk 0 has reached the LSBs.
    always_comb begin
        d_ext              = '0;
        d_ext[CHUNK-1:0]   = sl_d;
        acc_nxt            = (acc >> CHUNK) | (d_ext << (WIDTH - CHUNK));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
`ifdef SUB_OVERFLOW_FLAG_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else if (accept) begin
            a_sh  <= A;
            b_sh  <= B;
            brw   <= bin;
            cnt   <= '0;
`ifdef SUB_OVERFLOW_FLAG_EN
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
`endif
        end else if (state == ST_CALC) begin
            a_sh <= a_sh >> CHUNK;
            b_sh <= b_sh >> CHUNK;
            brw  <= sl_bout;
            acc  <= acc_nxt;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST) begin
                diff <= acc_nxt;
                bout <= sl_bout;
`ifdef SUB_OVERFLOW_FLAG_EN
                ovf  <= (a_msb != b_msb) && (acc_nxt[WIDTH-1] != a_msb);
`endif
            end
        end
    end

endmodule

// File: tb/tb_subtractor_seq.sv
// Randomized and directed bench for subtractor_seq against a plain-arithmetic subtraction model.
module tb_subtractor_seq;
    import alu_pkg::*;

    localparam int WIDTH = WIDTH_DEF;
    localparam int CHUNK = CHUNK_DEF;
    localparam int N     = WIDTH / CHUNK;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic             bin   = 1'b0;
    logic [WIDTH-1:0] a_in  = '0;
    logic [WIDTH-1:0] b_in  = '0;
    logic             busy, done, bout;
    logic [WIDTH-1:0] diff;
`ifdef SUB_OVERFLOW_FLAG_EN
    logic             ovf;
    logic             held_ovf = 1'b0;
`endif

    int               n_chk  = 0;
    int               n_fail = 0;
    logic [WIDTH-1:0] held_diff = '0;
    logic             held_bout = 1'b0;

    subtractor_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SUB_OVERFLOW_FLAG_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic bi);
        return {1'b0, a} - {1'b0, b} - (WIDTH+1)'(bi);
    endfunction

    function automatic logic ref_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic [WIDTH-1:0] d);
        return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
    endfunction

    task automatic check_result(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic bi);
        logic [WIDTH:0] e;
        e = ref_sub(a, b, bi);
        check({tag, "_diff"}, 64'(diff), 64'(e[WIDTH-1:0]));
        check({tag, "_bout"}, 64'(bout), 64'(e[WIDTH]));
        check({tag, "_busy"}, 64'(busy), 64'(0));
`ifdef SUB_OVERFLOW_FLAG_EN
        check({tag, "_ovf"}, 64'(ovf), 64'(ref_ovf(a, b, e[WIDTH-1:0])));
        held_ovf  = ref_ovf(a, b, e[WIDTH-1:0]);
`endif
        held_diff = e[WIDTH-1:0];
        held_bout = e[WIDTH];
    endtask

    // One operation; optional stray start pulse in the second CALC cycle with junk operands.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi,
                          input bit poke);
        int lat;
        lat = 0;
        @(negedge clk);
        a_in = a; b_in = b; bin = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a_in  = $urandom; b_in = $urandom; bin = 1'($urandom_range(0, 1));
        check("accept_busy", 64'(busy), 64'(1));
        for (int i = 1; i <= 20; i++) begin
            start = poke && (i == 2);
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
            check("calc_hold_diff", 64'(diff), 64'(held_diff));
            check("calc_hold_bout", 64'(bout), 64'(held_bout));
        end
        start = 1'b0;
        check("latency", 64'(lat), 64'(N));
        check_result("op", a, b, bi);
        @(posedge clk); #1;
        check("done_pulse_len", 64'(done), 64'(0));
        check("idle_after_done", 64'(busy), 64'(0));
    endtask

    task automatic back_to_back(input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                                input logic [WIDTH-1:0] a2, input logic [WIDTH-1:0] b2);
        int gap;
        bit seen;
        gap  = 0;
        seen = 1'b0;
        @(negedge clk);
        a_in = a1; b_in = b1; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a_in = a2; b_in = b2;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("b2b_first_done", 64'(seen), 64'(1));
        check_result("b2b_first", a1, b1, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                start = 1'b0;
                check("b2b_second_busy", 64'(busy), 64'(1));
            end
            if (done) begin
                gap = i;
                break;
            end
        end
        check("b2b_gap", 64'(gap), 64'(N + 1));
        check_result("b2b_second", a2, b2, 1'b0);
    endtask

    logic [WIDTH-1:0] va [7] = '{32'h10101100, 32'h0, 32'h0, 32'h100, 32'h80000000, 32'h5, 32'hDEADBEEF};
    logic [WIDTH-1:0] vb [7] = '{32'h10101010, 32'h1, 32'h0, 32'h1, 32'h1, 32'h3, 32'hDEADBEEF};
    logic             vi [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [WIDTH-1:0] vd [7] = '{32'hF0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFF, 32'h7FFFFFFF, 32'h2, 32'h0};
    logic             vo [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_diff", 64'(diff), 64'(0));
        check("rst_bout", 64'(bout), 64'(0));
`ifdef SUB_OVERFLOW_FLAG_EN
        check("rst_ovf", 64'(ovf), 64'(0));
`endif
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        for (int k = 0; k < 7; k++) begin
            run_op(va[k], vb[k], vi[k], (k == 0));
            check("directed_diff", 64'(diff), 64'(vd[k]));
            check("directed_bout", 64'(bout), 64'(vo[k]));
        end
`ifdef SUB_OVERFLOW_FLAG_EN
        run_op(32'h80000000, 32'h1, 1'b0, 1'b0);
        check("directed_ovf_set", 64'(ovf), 64'(1));
        run_op(32'h5, 32'h3, 1'b0, 1'b0);
        check("directed_ovf_clr", 64'(ovf), 64'(0));
`endif

        back_to_back(32'h12345678, 32'h00000079, 32'h00000000, 32'h00000002);

        // Abort an operation two cycles into CALC.
        @(negedge clk);
        a_in = 32'h00FF00FF; b_in = 32'h1; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_diff", 64'(diff), 64'(0));
        check("midrst_bout", 64'(bout), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        held_diff = '0;
        held_bout = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < N + 2; i++) begin
            @(posedge clk); #1;
            check("midrst_no_done", 64'(done), 64'(0));
        end
        run_op(32'h00000100, 32'h00000001, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : WIDTH'($urandom);
            run_op(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
